// File: rtl/vx_ahb_burst_adapter_if.sv
// AHB-Lite manager/subordinate signal bundle used by the Vortex burst adapter.
interface ahb_if #(
  parameter int DW = 32
);
  logic          HSEL;
  logic [31:0]   HADDR;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic [DW/8-1:0] HWSTRB;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  modport manager (
    output HSEL, HADDR, HWRITE, HTRANS, HBURST, HSIZE, HWDATA, HWSTRB,
    input  HRDATA, HREADY, HRESP
  );
  modport subordinate (
    input  HSEL, HADDR, HWRITE, HTRANS, HBURST, HSIZE, HWDATA, HWSTRB,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/vx_ahb_burst_adapter.sv
// Turns one Vortex cache-line request into one pipelined AHB-Lite INCR burst,
// with wait-state support and two-cycle ERROR cancellation.
module vx_ahb_burst_adapter #(
  parameter int VX_DATA_WIDTH  = 512,
  parameter int VX_ADDR_WIDTH  = 32 - $clog2(VX_DATA_WIDTH/8),
  parameter int VX_TAG_WIDTH   = 56,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int BEATS          = VX_DATA_WIDTH/AHB_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       mem_req_valid,
  output logic                       mem_req_ready,
  input  logic                       mem_req_rw,
  input  logic [VX_DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [VX_ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [VX_DATA_WIDTH-1:0]   mem_req_data,
  input  logic [VX_TAG_WIDTH-1:0]    mem_req_tag,
  output logic                       mem_rsp_valid,
  input  logic                       mem_rsp_ready,
  output logic [VX_DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [VX_TAG_WIDTH-1:0]    mem_rsp_tag,
  output logic                       mem_rsp_err,
  output logic                       wr_err,
  ahb_if.manager                     ahb
);
  localparam int LOG_LINE = $clog2(VX_DATA_WIDTH/8);
  localparam int LOG_BEAT = $clog2(AHB_DATA_WIDTH/8);
  localparam int SW       = AHB_DATA_WIDTH/8;
  localparam int CW       = $clog2(BEATS) + 1;
  localparam int IW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [2:0] BURST_CODE = (BEATS == 1)  ? 3'b000 :
                                      (BEATS == 4)  ? 3'b011 :
                                      (BEATS == 8)  ? 3'b101 :
                                      (BEATS == 16) ? 3'b111 : 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR2, S_RSP} state_t;

  state_t                               r_state, w_next;
  logic                                 r_rw, r_err, r_wr_err;
  logic [VX_TAG_WIDTH-1:0]              r_tag;
  logic [31:0]                          r_base;
  logic [BEATS-1:0][AHB_DATA_WIDTH-1:0] r_data, r_rdata;
  logic [BEATS-1:0][SW-1:0]             r_strb;
  logic [CW-1:0]                        r_a, r_d;

  logic w_addr_ph, w_data_ph, w_err1, w_issue, w_abeat_ok, w_dbeat_ok;
  logic [IW-1:0]                         w_didx;
  logic [VX_ADDR_WIDTH+LOG_LINE-1:0]     w_line;

  assign w_line     = {mem_req_addr, {LOG_LINE{1'b0}}};
  assign w_didx     = r_d[IW-1:0];
  assign w_addr_ph  = (r_state == S_BURST) && (r_a < CW'(BEATS));
  assign w_data_ph  = (r_state == S_BURST) && (r_d < r_a);
  // First ERROR cycle: the pending address beat is cancelled by driving IDLE.
  assign w_err1     = w_data_ph && ahb.HRESP && !ahb.HREADY;
  assign w_issue    = w_addr_ph && !w_err1;
  assign w_dbeat_ok = w_data_ph && ahb.HREADY && !ahb.HRESP;
  assign w_abeat_ok = w_addr_ph && ahb.HREADY && !(w_data_ph && ahb.HRESP);

  always_comb begin
    w_next      = r_state;
    ahb.HSEL    = 1'b0;
    ahb.HADDR   = '0;
    ahb.HWRITE  = 1'b0;
    ahb.HTRANS  = 2'b00;
    ahb.HBURST  = 3'b000;
    ahb.HSIZE   = 3'b000;
    ahb.HWDATA  = '0;
    ahb.HWSTRB  = '0;
    if (w_issue) begin
      ahb.HSEL   = 1'b1;
      ahb.HADDR  = r_base + (32'(r_a) << LOG_BEAT);
      ahb.HWRITE = r_rw;
      ahb.HTRANS = (r_a == '0) ? 2'b10 : 2'b11;
      ahb.HBURST = BURST_CODE;
      ahb.HSIZE  = 3'(LOG_BEAT);
    end
    if (w_data_ph) begin
      ahb.HWDATA = r_data[w_didx];
      ahb.HWSTRB = r_rw ? r_strb[w_didx] : '0;
    end
    case (r_state)
      S_IDLE:  if (mem_req_valid) w_next = S_BURST;
      S_BURST: begin
        if (w_err1)
          w_next = S_ERR2;
        else if (w_dbeat_ok && (r_d == CW'(BEATS-1)))
          w_next = r_rw ? S_IDLE : S_RSP;
      end
      S_ERR2:  if (ahb.HREADY) w_next = r_rw ? S_IDLE : S_RSP;
      S_RSP:   if (mem_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_rw     <= 1'b0;
      r_err    <= 1'b0;
      r_wr_err <= 1'b0;
      r_tag    <= '0;
      r_base   <= '0;
      r_data   <= '0;
      r_strb   <= '0;
      r_rdata  <= '0;
      r_a      <= '0;
      r_d      <= '0;
    end else begin
      r_state  <= w_next;
      r_wr_err <= 1'b0;
      case (r_state)
        S_IDLE: if (mem_req_valid) begin
          r_rw    <= mem_req_rw;
          r_tag   <= mem_req_tag;
          r_data  <= mem_req_data;
          r_strb  <= mem_req_byteen;
          r_base  <= 32'(w_line);
          r_a     <= '0;
          r_d     <= '0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        S_BURST: begin
          if (w_abeat_ok) r_a <= r_a + CW'(1);
          if (w_dbeat_ok) begin
            r_d <= r_d + CW'(1);
            if (!r_rw) r_rdata[w_didx] <= ahb.HRDATA;
          end
        end
        S_ERR2: if (ahb.HREADY) begin
          if (r_rw) r_wr_err <= 1'b1;
          else      r_err    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_req_ready = (r_state == S_IDLE) && nRST;
  assign mem_rsp_valid = (r_state == S_RSP);
  assign mem_rsp_data  = r_rdata;
  assign mem_rsp_tag   = r_tag;
  assign mem_rsp_err   = (r_state == S_RSP) && r_err;
  assign wr_err        = r_wr_err;
endmodule

// File: tb/tb_vx_ahb_burst_adapter.sv
// Directed bench: 32-bit (16-beat) adapter plus a 64-bit (8-beat) instance.
module tb_vx_ahb_burst_adapter;
  logic clk = 1'b0, nRST = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // 32-bit instance
  logic         req_valid, req_ready, req_rw, rsp_valid, rsp_ready, rsp_err, wr_err;
  logic [63:0]  req_be;
  logic [25:0]  req_addr;
  logic [511:0] req_data, rsp_data;
  logic [55:0]  req_tag, rsp_tag;
  logic         hready, hresp;
  logic [31:0]  r_dph;
  ahb_if #(.DW(32)) ahb1();
  assign ahb1.HREADY = hready;
  assign ahb1.HRESP  = hresp;
  assign ahb1.HRDATA = 32'hA500_0000 ^ r_dph;
  always @(posedge clk or negedge nRST)
    if (!nRST) r_dph <= '0;
    else if (hready && ahb1.HTRANS[1]) r_dph <= ahb1.HADDR;

  vx_ahb_burst_adapter dut (
    .clk(clk), .nRST(nRST),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_rw(req_rw),
    .mem_req_byteen(req_be), .mem_req_addr(req_addr), .mem_req_data(req_data),
    .mem_req_tag(req_tag), .mem_rsp_valid(rsp_valid), .mem_rsp_ready(rsp_ready),
    .mem_rsp_data(rsp_data), .mem_rsp_tag(rsp_tag), .mem_rsp_err(rsp_err),
    .wr_err(wr_err), .ahb(ahb1)
  );

  // 64-bit instance, zero-wait slave
  logic         b_valid, b_ready, b_rw, b_rsp_valid, b_rsp_ready, b_rsp_err, b_wr_err;
  logic [63:0]  b_be;
  logic [25:0]  b_addr;
  logic [511:0] b_data, b_rsp_data;
  logic [55:0]  b_tag, b_rsp_tag;
  logic [31:0]  b_dph;
  ahb_if #(.DW(64)) ahb2();
  assign ahb2.HREADY = 1'b1;
  assign ahb2.HRESP  = 1'b0;
  assign ahb2.HRDATA = {32'hC3C3_0000 ^ b_dph, 32'hA500_0000 ^ b_dph};
  always @(posedge clk or negedge nRST)
    if (!nRST) b_dph <= '0;
    else if (ahb2.HTRANS[1]) b_dph <= ahb2.HADDR;

  vx_ahb_burst_adapter #(.AHB_DATA_WIDTH(64)) dut64 (
    .clk(clk), .nRST(nRST),
    .mem_req_valid(b_valid), .mem_req_ready(b_ready), .mem_req_rw(b_rw),
    .mem_req_byteen(b_be), .mem_req_addr(b_addr), .mem_req_data(b_data),
    .mem_req_tag(b_tag), .mem_rsp_valid(b_rsp_valid), .mem_rsp_ready(b_rsp_ready),
    .mem_rsp_data(b_rsp_data), .mem_rsp_tag(b_rsp_tag), .mem_rsp_err(b_rsp_err),
    .wr_err(b_wr_err), .ahb(ahb2)
  );

  function automatic logic [511:0] line32(input logic [31:0] base, input int n);
    logic [511:0] v = '0;
    for (int k = 0; k < n; k++) v[k*32 +: 32] = 32'hA500_0000 ^ (base + 32'(4*k));
    return v;
  endfunction

  function automatic logic [511:0] line64(input logic [31:0] base);
    logic [511:0] v = '0;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = base + 32'(8*k);
      v[k*64 +: 64] = {32'hC3C3_0000 ^ a, 32'hA500_0000 ^ a};
    end
    return v;
  endfunction

  task automatic send(input logic rw, input logic [25:0] a, input logic [55:0] t,
                      input logic [511:0] d, input logic [63:0] be);
    req_rw = rw; req_addr = a; req_tag = t; req_data = d; req_be = be; req_valid = 1'b1;
    #1;
    chk("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  logic [511:0] wdat;

  initial begin
    req_valid = 0; req_rw = 0; req_be = '0; req_addr = '0; req_data = '0; req_tag = '0;
    rsp_ready = 1; hready = 1; hresp = 0;
    b_valid = 0; b_rw = 0; b_be = '0; b_addr = '0; b_data = '0; b_tag = '0; b_rsp_ready = 1;
    for (int k = 0; k < 16; k++) wdat[k*32 +: 32] = 32'hD000_0000 + 32'(k);

    // reset state
    #12;
    chk("rst_htrans", ahb1.HTRANS, 0);  chk("rst_hsel", ahb1.HSEL, 0);
    chk("rst_haddr", ahb1.HADDR, 0);    chk("rst_hwrite", ahb1.HWRITE, 0);
    chk("rst_hwdata", ahb1.HWDATA, 0);  chk("rst_hwstrb", ahb1.HWSTRB, 0);
    chk("rst_hburst", ahb1.HBURST, 0);  chk("rst_hsize", ahb1.HSIZE, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_err", rsp_err, 0);
    chk("rst_wr_err", wr_err, 0);       chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    nRST = 1;
    tick();
    chk("rst_ready", req_ready, 1);

    // zero-wait read, base 0x40
    send(0, 26'h1, 56'hAB, '0, '0);
    for (int k = 0; k < 16; k++) begin
      chk("rd_htrans", ahb1.HTRANS, (k == 0) ? 2'b10 : 2'b11);
      chk("rd_haddr", ahb1.HADDR, 32'h40 + 32'(4*k));
      if (k == 0) begin
        chk("rd_hburst", ahb1.HBURST, 3'b111); chk("rd_hsize", ahb1.HSIZE, 3'b010);
        chk("rd_hsel", ahb1.HSEL, 1);          chk("rd_hwrite", ahb1.HWRITE, 0);
      end
      tick();
    end
    chk("rd_idle17", ahb1.HTRANS, 0);
    chk("rd_nvalid17", rsp_valid, 0);
    tick();
    chk("rd_valid18", rsp_valid, 1);
    chk("rd_data", rsp_data, line32(32'h40, 16));
    chk("rd_tag", rsp_tag, 56'hAB);
    chk("rd_err", rsp_err, 0);
    chk("rd_busy", req_ready, 0);
    tick();
    chk("rd_ready19", req_ready, 1);
    chk("rd_nvalid19", rsp_valid, 0);

    // write, byteen 0xF0
    send(1, 26'h2, 56'h12, wdat, 64'hF0);
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16) chk("wr_hwrite", ahb1.HWRITE, 1);
      if (c >= 2) begin
        chk("wr_hwdata", ahb1.HWDATA, wdat[(c-2)*32 +: 32]);
        chk("wr_hwstrb", ahb1.HWSTRB, (c == 3) ? 4'hF : 4'h0);
      end
      if (c == 17) chk("wr_busy17", req_ready, 0);
      chk("wr_nvalid", rsp_valid, 0);
      tick();
    end
    chk("wr_ready18", req_ready, 1);

    // two wait states on address beat 5, base 0x80
    send(0, 26'h2, 56'h77, wdat, '0);
    for (int c = 1; c <= 19; c++) begin
      hready = !(c == 6 || c == 7);
      #1;
      if (c == 6 || c == 7) begin
        chk("ws_haddr", ahb1.HADDR, 32'h94);
        chk("ws_htrans", ahb1.HTRANS, 2'b11);
        chk("ws_hwdata", ahb1.HWDATA, wdat[4*32 +: 32]);
      end
      if (c == 19) chk("ws_nvalid19", rsp_valid, 0);
      tick();
    end
    hready = 1;
    chk("ws_valid20", rsp_valid, 1);
    chk("ws_data", rsp_data, line32(32'h80, 16));
    tick();

    // read ERROR on beat 3 with response backpressure, base 0xC0
    rsp_ready = 0;
    send(0, 26'h3, 56'h3E, '0, '0);
    for (int c = 1; c <= 6; c++) begin
      hresp = (c == 5 || c == 6); hready = (c != 5);
      #1;
      if (c == 5) chk("er_cancel", ahb1.HTRANS, 0);
      if (c == 6) chk("er_err2", ahb1.HTRANS, 0);
      tick();
    end
    hresp = 0; hready = 1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_err", rsp_err, 1);
      chk("bp_data", rsp_data, line32(32'hC0, 3));
      chk("bp_tag", rsp_tag, 56'h3E);
      chk("bp_busy", req_ready, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("bp_ready", req_ready, 1);
    chk("bp_nvalid", rsp_valid, 0);

    // write ERROR on beat 1
    send(1, 26'h4, 56'h44, wdat, '1);
    for (int c = 1; c <= 4; c++) begin
      hresp = (c == 3 || c == 4); hready = (c != 3);
      #1;
      if (c == 4) chk("we_early", wr_err, 0);
      tick();
    end
    hresp = 0; hready = 1;
    chk("we_pulse", wr_err, 1);
    chk("we_nvalid", rsp_valid, 0);
    chk("we_ready", req_ready, 1);
    tick();
    chk("we_once", wr_err, 0);

    // reset while d = 7, base 0x140
    send(0, 26'h5, 56'h99, '0, '0);
    repeat (8) tick();
    chk("mr_haddr", ahb1.HADDR, 32'h160);
    nRST = 0;
    #1;
    chk("mr_htrans", ahb1.HTRANS, 0);
    chk("mr_hsel", ahb1.HSEL, 0);
    chk("mr_haddr0", ahb1.HADDR, 0);
    #3;
    nRST = 1;
    tick();
    chk("mr_ready", req_ready, 1);
    send(0, 26'h6, 56'h66, '0, '0);
    chk("mr_nonseq", ahb1.HTRANS, 2'b10);
    chk("mr_haddr_new", ahb1.HADDR, 32'h180);
    repeat (17) tick();
    chk("mr_valid", rsp_valid, 1);
    chk("mr_data", rsp_data, line32(32'h180, 16));
    chk("mr_tag", rsp_tag, 56'h66);
    tick();

    // 64-bit bus, 8 beats, base 0x40
    b_addr = 26'h1; b_tag = 56'hBB; b_rw = 0; b_valid = 1;
    #1;
    chk("w64_ready", b_ready, 1);
    tick();
    b_valid = 0;
    for (int k = 0; k < 8; k++) begin
      chk("w64_htrans", ahb2.HTRANS, (k == 0) ? 2'b10 : 2'b11);
      chk("w64_haddr", ahb2.HADDR, 32'h40 + 32'(8*k));
      if (k == 0) begin
        chk("w64_hburst", ahb2.HBURST, 3'b101);
        chk("w64_hsize", ahb2.HSIZE, 3'b011);
      end
      tick();
    end
    chk("w64_nvalid9", b_rsp_valid, 0);
    tick();
    chk("w64_valid10", b_rsp_valid, 1);
    chk("w64_data", b_rsp_data, line64(32'h40));
    chk("w64_tag", b_rsp_tag, 56'hBB);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
